// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the sequential ALU.
//   op_e     - 4-bit opcode encoding (11..15 illegal)
//   flags_t  - packed {N,V,C,Z} status flags
//   state_e  - control FSM states
//   Flag*    - bit positions of each flag inside flags_t
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpAnd  = 4'd2,
    OpOr   = 4'd3,
    OpXor  = 4'd4,
    OpShl  = 4'd5,
    OpShr  = 4'd6,
    OpSlt  = 4'd7,
    OpSlts = 4'd8,
    OpSra  = 4'd9,
    OpMul  = 4'd10
  } op_e;

  typedef struct packed {
    logic n;
    logic v;
    logic c;
    logic z;
  } flags_t;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StMulBusy = 1'b1
  } state_e;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagV = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagZ = 0;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one partial product per cycle.
// Returns the low WIDTH bits of the unsigned product a_i * b_i.
//   clk, rst   - clock, asynchronous active-high reset
//   start_i    - capture operands and perform the first iteration this edge
//   a_i, b_i   - operands (sampled only when start_i is high)
//   done_o     - all WIDTH iterations complete; product_o valid until next start
//   product_o  - low WIDTH bits of the product
// The first iteration runs on the start edge so that done_o is high in the
// cycle before edge start+WIDTH, letting the parent register the product on
// exactly that edge.
module alu_seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    done_o   = (cnt_q == CntW'(WIDTH));
    if (start_i) begin
      acc_d    = b_i[0] ? a_i : '0;
      mcand_d  = a_i << 1;
      mplier_d = b_i >> 1;
      cnt_d    = CntW'(1);
    end else if ((cnt_q != '0) && !done_o) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with a registered result stage.
// Single-cycle ops complete on the accept edge; MUL (when ALU_SEQ_MUL_EN is
// defined) runs an iterative multiplier and delivers WIDTH cycles after accept.
// Without ALU_SEQ_MUL_EN there is no FSM and opcode 10 is illegal.
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - request handshake; a, b, op captured on accept
//   out_valid/out_ready - result handshake; result/flags/out_err held while stalled
//   result              - registered result (WIDTH bits)
//   flags               - registered {N,V,C,Z}
//   out_err             - registered illegal-opcode indicator
// WIDTH must be a power of two and at least 4.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             out_err
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;
  logic             out_err_q, out_err_d;

  logic             out_free;
  logic             accept;
  logic             load_alu;

  // Combinational single-cycle datapath
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;
  logic             alu_err;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};  // diff[WIDTH] is the unsigned borrow
    shamt   = b[ShW-1:0];
    alu_res = '0;
    alu_err = 1'b0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OpAdd: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd:  alu_res = a & b;
      OpOr:   alu_res = a | b;
      OpXor:  alu_res = a ^ b;
      OpShl:  alu_res = a << shamt;
      OpShr:  alu_res = a >> shamt;
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OpSlts: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSra:  alu_res = $signed(a) >>> shamt;
`ifdef ALU_SEQ_MUL_EN
      OpMul:  alu_res = '0;  // product comes from alu_seq_mul, never from here
`endif
      default: alu_err = 1'b1;
    endcase
    alu_flags.n = alu_res[WIDTH-1];
    alu_flags.v = alu_v;
    alu_flags.c = alu_c;
    alu_flags.z = (alu_res == '0);
    // Illegal ops report all-zero flags even though result is zero
    if (alu_err) alu_flags = '0;
  end

`ifdef ALU_SEQ_MUL_EN
  state_e           state_q, state_d;
  logic             mul_start;
  logic             mul_done;
  logic             load_mul;
  logic [WIDTH-1:0] mul_product;

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .a_i      (a),
    .b_i      (b),
    .done_o   (mul_done),
    .product_o(mul_product)
  );
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_err_d   = out_err_q;
    out_free    = !out_valid_q || out_ready;
`ifdef ALU_SEQ_MUL_EN
    state_d   = state_q;
    in_ready  = (state_q == StIdle) && out_free;
    accept    = in_valid && in_ready;
    mul_start = accept && (op == OpMul);
    load_alu  = accept && !mul_start;
    // Hold the finished product inside the multiplier until the output frees
    load_mul  = (state_q == StMulBusy) && mul_done && out_free;
    unique case (state_q)
      StIdle:    if (mul_start) state_d = StMulBusy;
      StMulBusy: if (load_mul) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
`else
    in_ready = out_free;
    accept   = in_valid && in_ready;
    load_alu = accept;
`endif
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (load_alu) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      flags_d     = alu_flags;
      out_err_d   = alu_err;
    end
`ifdef ALU_SEQ_MUL_EN
    if (load_mul) begin
      out_valid_d = 1'b1;
      result_d    = mul_product;
      flags_d.n   = mul_product[WIDTH-1];
      flags_d.v   = 1'b0;
      flags_d.c   = 1'b0;
      flags_d.z   = (mul_product == '0);
      out_err_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_err_q   <= out_err_d;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end
`endif

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=8).
// MUL vectors run when ALU_SEQ_MUL_EN is defined; otherwise opcode 10 is
// checked as illegal.
module tb_alu_seq;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         out_err;

  int unsigned n_checks;
  int unsigned n_pass;

  alu_seq #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags),
    .out_err  (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present one op at the negedge, let it be accepted on the next posedge,
  // return #1 after that edge with in_valid dropped.
  task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Check one completed single-cycle result: value, {N,V,C,Z}, err, valid.
  task automatic check_res(input string tag, input logic [W-1:0] r, input logic [3:0] f,
                           input logic e);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_res"}, {24'd0, result}, {24'd0, r});
    check_eq({tag, "_flags"}, {28'd0, flags}, {28'd0, f});
    check_eq({tag, "_err"}, {31'd0, out_err}, {31'd0, e});
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = '0;

    // Reset state
    #12;
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_res", {24'd0, result}, 32'd0);
    check_eq("rst_flags", {28'd0, flags}, 32'd0);
    check_eq("rst_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_ready", {31'd0, in_ready}, 32'd1);

    // Single-cycle ops, flags are {N,V,C,Z}
    do_op(4'd0, 8'h7F, 8'h01); check_res("add_ovf",  8'h80, 4'b1100, 1'b0);
    do_op(4'd1, 8'h03, 8'h05); check_res("sub_brw",  8'hFE, 4'b1010, 1'b0);
    do_op(4'd7, 8'hFE, 8'h02); check_res("slt",      8'h00, 4'b0001, 1'b0);
    do_op(4'd8, 8'hFE, 8'h02); check_res("slts",     8'h01, 4'b0000, 1'b0);
    do_op(4'd0, 8'hFF, 8'h01); check_res("add_cz",   8'h00, 4'b0011, 1'b0);
    do_op(4'd1, 8'h80, 8'h01); check_res("sub_ovf",  8'h7F, 4'b0100, 1'b0);
    do_op(4'd2, 8'hF0, 8'h3C); check_res("and",      8'h30, 4'b0000, 1'b0);
    do_op(4'd3, 8'h0F, 8'hA0); check_res("or",       8'hAF, 4'b1000, 1'b0);
    do_op(4'd4, 8'hA5, 8'hA5); check_res("xor",      8'h00, 4'b0001, 1'b0);
    do_op(4'd5, 8'h81, 8'h09); check_res("shl",      8'h02, 4'b0000, 1'b0);
    do_op(4'd6, 8'h81, 8'h0F); check_res("shr",      8'h01, 4'b0000, 1'b0);
    do_op(4'd9, 8'h80, 8'h03); check_res("sra",      8'hF0, 4'b1000, 1'b0);
    do_op(4'd15, 8'h12, 8'h34); check_res("illegal", 8'h00, 4'b0000, 1'b1);
    do_op(4'd0, 8'h01, 8'h01); check_res("err_clr",  8'h02, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    check_eq("drain_valid", {31'd0, out_valid}, 32'd0);

    // Back-pressure: first result held, second accepted when out_ready rises
    out_ready = 1'b0;
    do_op(4'd0, 8'h01, 8'h02);
    in_valid = 1'b1;
    op       = 4'd0;
    a        = 8'h10;
    b        = 8'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_ready", {31'd0, in_ready}, 32'd0);
      check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
      check_eq("stall_res", {24'd0, result}, 32'h03);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check_eq("unstall_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_res("second_add", 8'h30, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    check_eq("second_drain", {31'd0, out_valid}, 32'd0);

    // Async reset while a stalled result is held
    out_ready = 1'b0;
    do_op(4'd0, 8'h05, 8'h05);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("async_rst_res", {24'd0, result}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("post_rst_ready", {31'd0, in_ready}, 32'd1);

`ifdef ALU_SEQ_MUL_EN
    // MUL latency: out_valid rises exactly 8 edges after accept
    do_op(4'd10, 8'h0C, 8'h0B);
    a = 8'hFF;
    b = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      check_eq("mul_busy_ready", {31'd0, in_ready}, 32'd0);
      check_eq("mul_busy_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    check_res("mul", 8'h84, 4'b1000, 1'b0);
    @(posedge clk);
    #1;

    // Reset mid-multiply: no product ever appears
    do_op(4'd10, 8'h0C, 8'h0B);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mul_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mul_rst_ready", {31'd0, in_ready}, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check_eq("mul_abort_valid", {31'd0, out_valid}, 32'd0);
`else
    // Without the multiplier, opcode 10 is illegal with latency 1
    do_op(4'd10, 8'h0C, 8'h0B);
    check_res("mul_illegal", 8'h00, 4'b0000, 1'b1);
    @(posedge clk);
    #1;
`endif

    do_op(4'd0, 8'h00, 8'h00);
    check_res("zero_add", 8'h00, 4'b0001, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
